// File: rtl/sipo_load_ctrl.sv
// Serial-in/parallel-out load controller: shifts WIDTH serial bits into a word and holds it
// until accepted via valid/ready. Define SIPO_PARITY_EN to add a trailing even-parity bit.
module sipo_load_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             in_i,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_valid_o,
`ifdef SIPO_PARITY_EN
  output logic             parity_err_o,
`endif
  output logic             busy_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StShift  = 2'd1,
    StHold   = 2'd2,
    StParity = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
`ifdef SIPO_PARITY_EN
  logic              perr_q, perr_d;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
`ifdef SIPO_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
`ifdef SIPO_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef SIPO_PARITY_EN
    perr_d  = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StShift;
          cnt_d   = '0;
          data_d  = '0;
`ifdef SIPO_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      StShift: begin
        if (MSB_FIRST != 0) data_d = {data_q[WIDTH-2:0], in_i};
        else                data_d = {in_i, data_q[WIDTH-1:1]};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
`ifdef SIPO_PARITY_EN
          state_d = StParity;
`else
          state_d = StHold;
`endif
        end
      end
      StParity: begin
`ifdef SIPO_PARITY_EN
        perr_d = (^data_q) ^ in_i;
`endif
        state_d = StHold;
      end
      StHold: begin
        if (out_ready_i) begin
          if (start_i) begin
            // Back-to-back load skips IDLE entirely.
            state_d = StShift;
            cnt_d   = '0;
            data_d  = '0;
`ifdef SIPO_PARITY_EN
            perr_d  = 1'b0;
`endif
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign out_data_o  = data_q;
  assign out_valid_o = (state_q == StHold);
  assign busy_o      = (state_q == StShift) || (state_q == StParity);
`ifdef SIPO_PARITY_EN
  assign parity_err_o = perr_q;
`endif

endmodule

// File: tb/tb_sipo_load_ctrl.sv
// Directed bench: one MSB-first and one LSB-first instance driven by the same stimulus.
module tb_sipo_load_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       start_i = 1'b0;
  logic       in_i = 1'b0;
  logic       out_ready_i = 1'b0;
  logic [7:0] data_m, data_l;
  logic       valid_m, valid_l, busy_m, busy_l;
`ifdef SIPO_PARITY_EN
  logic       perr_m, perr_l;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  sipo_load_ctrl #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .in_i        (in_i),
    .out_ready_i (out_ready_i),
    .out_data_o  (data_m),
    .out_valid_o (valid_m),
`ifdef SIPO_PARITY_EN
    .parity_err_o(perr_m),
`endif
    .busy_o      (busy_m)
  );

  sipo_load_ctrl #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .in_i        (in_i),
    .out_ready_i (out_ready_i),
    .out_data_o  (data_l),
    .out_valid_o (valid_l),
`ifdef SIPO_PARITY_EN
    .parity_err_o(perr_l),
`endif
    .busy_o      (busy_l)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Shifts stream[7] first; checks status along the way and the final words.
  task automatic shift_bits(input string name, input logic [7:0] stream, input logic par,
                            input logic [7:0] exp_m, input logic [7:0] exp_l);
    for (int i = 7; i >= 0; i--) begin
      in_i = stream[i];
      tick();
`ifdef SIPO_PARITY_EN
      if (1) begin
`else
      if (i != 0) begin
`endif
        checks++;
        if ({busy_m, busy_l, valid_m, valid_l} !== 4'b1100) begin
          errors++;
          $display("FAIL %s_shift_status bit%0d: got busy=%b%b valid=%b%b want busy=11 valid=00",
                   name, 7 - i, busy_m, busy_l, valid_m, valid_l);
        end
      end
    end
`ifdef SIPO_PARITY_EN
    in_i = par;
    tick();
`endif
    in_i = 1'b0;
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b0011) begin
      errors++;
      $display("FAIL %s_done_status: got busy=%b%b valid=%b%b want busy=00 valid=11",
               name, busy_m, busy_l, valid_m, valid_l);
    end
    checks++;
    if (data_m !== exp_m || data_l !== exp_l) begin
      errors++;
      $display("FAIL %s_data: got msb=%h lsb=%h want msb=%h lsb=%h",
               name, data_m, data_l, exp_m, exp_l);
    end
  endtask

  task automatic do_load(input string name, input logic [7:0] stream, input logic par,
                         input logic [7:0] exp_m, input logic [7:0] exp_l);
    start_i = 1'b1;
    in_i    = 1'b1;
    tick();
    start_i = 1'b0;
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b1100 || data_m !== 8'h00 || data_l !== 8'h00) begin
      errors++;
      $display("FAIL %s_start: got busy=%b%b valid=%b%b data=%h/%h want busy=11 valid=00 data=00/00",
               name, busy_m, busy_l, valid_m, valid_l, data_m, data_l);
    end
    shift_bits(name, stream, par, exp_m, exp_l);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    start_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_i = i[0];
      tick();
      checks++;
      if ({busy_m, busy_l, valid_m, valid_l} !== 4'b0000 || data_m !== 8'h00 || data_l !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got busy=%b%b valid=%b%b data=%h/%h want all zero",
                 i, busy_m, busy_l, valid_m, valid_l, data_m, data_l);
      end
    end
    start_i = 1'b0;
    rst_ni  = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b%b valid=%b%b want 0000",
               busy_m, busy_l, valid_m, valid_l);
    end
  endtask

  task automatic test_basic_load();
    out_ready_i = 1'b0;
    do_load("basic", 8'hB2, 1'b0, 8'hB2, 8'h4D);
  endtask

  task automatic test_hold_handshake();
    for (int i = 0; i < 5; i++) begin
      in_i    = ~i[0];
      start_i = i[0];
      tick();
      checks++;
      if (valid_m !== 1'b1 || valid_l !== 1'b1 || data_m !== 8'hB2 || data_l !== 8'h4D) begin
        errors++;
        $display("FAIL hold cyc%0d: got valid=%b%b data=%h/%h want valid=11 data=b2/4d",
                 i, valid_m, valid_l, data_m, data_l);
      end
    end
    start_i     = 1'b0;
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b0000 || data_m !== 8'hB2 || data_l !== 8'h4D) begin
      errors++;
      $display("FAIL accept: got busy=%b%b valid=%b%b data=%h/%h want 0000 data=b2/4d",
               busy_m, busy_l, valid_m, valid_l, data_m, data_l);
    end
    in_i = 1'b1;
    tick();
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_after_accept: got busy=%b%b valid=%b%b want 0000",
               busy_m, busy_l, valid_m, valid_l);
    end
  endtask

  task automatic test_reset_mid();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_i = 1'b1;
      tick();
    end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b0000 || data_m !== 8'h00 || data_l !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: got busy=%b%b valid=%b%b data=%h/%h want all zero",
               busy_m, busy_l, valid_m, valid_l, data_m, data_l);
    end
    tick();
    rst_ni = 1'b1;
    tick();
    do_load("fresh", 8'h3C, 1'b0, 8'h3C, 8'h3C);
  endtask

  task automatic test_back_to_back();
    out_ready_i = 1'b1;
    start_i     = 1'b1;
    tick();
    out_ready_i = 1'b0;
    start_i     = 1'b0;
    checks++;
    if ({busy_m, busy_l, valid_m, valid_l} !== 4'b1100 || data_m !== 8'h00 || data_l !== 8'h00) begin
      errors++;
      $display("FAIL b2b_restart: got busy=%b%b valid=%b%b data=%h/%h want busy=11 valid=00 data=0",
               busy_m, busy_l, valid_m, valid_l, data_m, data_l);
    end
    shift_bits("b2b", 8'hB2, 1'b0, 8'hB2, 8'h4D);
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

`ifdef SIPO_PARITY_EN
  task automatic test_parity();
    do_load("par1", 8'hA5, 1'b1, 8'hA5, 8'hA5);
    checks++;
    if (perr_m !== 1'b1 || perr_l !== 1'b1) begin
      errors++;
      $display("FAIL parity_err_set: got %b%b want 11", perr_m, perr_l);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
    do_load("par0", 8'hA5, 1'b0, 8'hA5, 8'hA5);
    checks++;
    if (perr_m !== 1'b0 || perr_l !== 1'b0) begin
      errors++;
      $display("FAIL parity_err_clr: got %b%b want 00", perr_m, perr_l);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_hold_handshake();
    test_reset_mid();
    test_back_to_back();
`ifdef SIPO_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sipo_load_ctrl.md
Name: sipo_load_ctrl

Overview:
- Controller that sequences a WIDTH-bit bank of D flip-flops as a serial-in/parallel-out shift register.
- Accepts a start request and samples one serial bit per clock for WIDTH clocks, then presents the assembled word.
- Holds the word until the consumer accepts it with a valid/ready handshake.
- Sits between the serial bit stream driven into the flip-flop labs and any parallel consumer (display, comparator, counter).

Parameters:
- WIDTH, 8, number of data bits per word (legal range 2..32).
- MSB_FIRST, 1, 1 = first serial bit lands in out_data[WIDTH-1]; 0 = first serial bit lands in out_data[0].

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to begin loading a word; sampled in IDLE, or in HOLD when the word is being accepted.
- in  input  1  serial data bit; sampled every SHIFT cycle.
- out_ready  input  1  consumer accepts out_data when high with out_valid.
- out_data  output  WIDTH  assembled word; stable while out_valid=1.
- out_valid  output  1  word complete and held.
- busy  output  1  high while in SHIFT (and PARITY, if compiled).
- parity_err  output  1  present only with PARITY_EN; see below.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, bit counter=0, out_data=0, out_valid=0, busy=0, parity_err=0.
  - Takes effect immediately, including mid-SHIFT. Any partial word is discarded.
- States: IDLE, SHIFT, HOLD (plus PARITY when PARITY_EN is defined). Bit counter width is clog2(WIDTH+1).
- IDLE:
  - busy=0, out_valid=0.
  - start=1 at a rising edge -> SHIFT; counter cleared; out_data cleared to 0.
  - in is ignored on that edge.
- SHIFT:
  - busy=1. Each rising edge samples in.
  - MSB_FIRST=1: out_data <= {out_data[WIDTH-2:0], in}.
  - MSB_FIRST=0: out_data <= {in, out_data[WIDTH-1:1]}.
  - Counter increments on each sampled bit.
  - On the edge sampling the WIDTH-th bit -> HOLD (or PARITY); out_valid=1 and busy=0 from that edge.
  - start is ignored throughout SHIFT.
- Latency: start at edge N -> bits sampled at edges N+1..N+WIDTH -> out_valid high after edge N+WIDTH.
- HOLD:
  - out_data and out_valid held indefinitely while out_ready=0.
  - Edge with out_ready=1 and start=0 -> IDLE; out_valid=0; out_data keeps its last value.
  - Edge with out_ready=1 and start=1 -> SHIFT directly (back-to-back load); out_valid=0; out_data cleared; counter cleared.
  - start with out_ready=0 is ignored.
- out_valid is never high while busy is high.
- in is never sampled outside SHIFT (and PARITY).

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, FSM enters PARITY for one cycle (busy=1) and samples in as an even-parity bit.
  - parity_err <= (^out_data) ^ in; then -> HOLD with out_valid=1.
  - Latency becomes WIDTH+1 edges.
  - parity_err is valid with out_valid and is cleared when the next SHIFT starts and on reset.
- Not defined: no PARITY state, no parity_err port; latency WIDTH edges.

Test Plan:
- Reset: hold reset=0 with start=1 and in toggling -> out_data=0, out_valid=0, busy=0 throughout; after release, remain in IDLE until start.
- Basic load (WIDTH=8, MSB_FIRST=1): start for 1 cycle, then in=1,0,1,1,0,0,1,0 -> busy=1 for 8 cycles; out_valid=1 after the 8th edge; out_data=8'hB2.
- Hold/handshake: keep out_ready=0 for 5 cycles after valid, toggle in and start -> out_data stays 8'hB2. Then out_ready=1 for 1 cycle -> out_valid=0 after that edge; state IDLE.
- Reset mid-operation: assert reset=0 asynchronously after 3 bits -> outputs 0 immediately. Then a fresh load of 8'h3C -> out_data=8'h3C with no residue.
- Back-to-back and MSB_FIRST=0: out_ready=1 and start=1 on the same edge -> no IDLE cycle, busy=1 next cycle. Serial 1,0,1,1,0,0,1,0 with MSB_FIRST=0 -> out_data=8'h4D.
- SIPO_PARITY_EN: load 8'hA5 with parity bit 1 -> parity_err=1, out_valid after 9 edges. Reload 8'hA5 with parity bit 0 -> parity_err=0.
